// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: data-bus endpoint backed by a word-addressed SRAM.
// Accepts one request at a time over the addr_ok/data_ok handshake and
// answers after a programmable number of wait cycles.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   dreq       request from the memory stage (valid/addr/size/strobe/data)
//   dresp      response (addr_ok combinational in IDLE, data_ok/data registered)
//   txn_count  completed transactions, wraps modulo 2^32
//   misalign   sticky flag: an accepted request was misaligned for its size

package dbus_pkg;
  typedef logic [2:0] msize_t;
  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;
endpackage

module dbus_sram_responder
  import dbus_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  dbus_req_t   dreq,
  output dbus_resp_t  dresp,
  output logic [31:0] txn_count,
  output logic        misalign
);
  localparam int IW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state;
  logic [3:0]     cnt;
  logic [IW-1:0]  idx_q;
  logic [3:0]     strb_q;
  logic [31:0]    wdata_q;
  logic           data_ok_q;
  logic [31:0]    rdata_q;
  logic [31:0]    mem [MEM_WORDS];

  logic [IW-1:0]  req_idx;
  logic           req_mis;
  logic           unused_ok;

  // Upper address bits alias; addr[1:0] only feeds the alignment check.
  assign req_idx = dreq.addr[IW+1:2];
  assign req_mis = ((dreq.size == MSIZE2) && dreq.addr[0]) ||
                   ((dreq.size == MSIZE4) && (dreq.addr[1:0] != 2'b00));
  assign unused_ok = ^dreq.addr[31:IW+2];

  assign dresp.addr_ok = (state == IDLE) && dreq.valid && !reset;
  assign dresp.data_ok = data_ok_q;
  assign dresp.data    = rdata_q;

  // Control FSM. The read word is captured on the edge entering RESP, so
  // a write's response carries the value before its own commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
      txn_count <= '0;
      misalign  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dreq.valid) begin
            idx_q    <= req_idx;
            strb_q   <= dreq.strobe;
            wdata_q  <= dreq.data;
            cnt      <= 4'(LATENCY);
            misalign <= misalign | req_mis;
            if (LATENCY > 0) begin
              state <= WAIT;
            end else begin
              state     <= RESP;
              data_ok_q <= 1'b1;
              rdata_q   <= mem[req_idx];
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state     <= RESP;
            data_ok_q <= 1'b1;
            rdata_q   <= mem[idx_q];
          end
        end
        RESP: begin
          state     <= IDLE;
          data_ok_q <= 1'b0;
          rdata_q   <= '0;
          txn_count <= txn_count + 32'd1;
        end
        default: begin
          state     <= IDLE;
          data_ok_q <= 1'b0;
          rdata_q   <= '0;
        end
      endcase
    end
  end

  // Byte-lane write commits on the edge ending RESP; a reset on that edge
  // discards it. Contents are not reset.
  always_ff @(posedge clk) begin
    if (!reset && state == RESP) begin
      for (int i = 0; i < 4; i++) begin
        if (strb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dbus_sram_responder.sv
module tb_dbus_sram_responder;
  import dbus_pkg::*;

  localparam int MW  = 1024;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  dbus_req_t   dreq0, dreq1;
  dbus_resp_t  dresp0, dresp1;
  logic [31:0] txn0, txn1;
  logic        mis0, mis1;

  dbus_sram_responder #(.MEM_WORDS(MW), .LATENCY(LAT)) u_lat2 (
    .clk(clk), .reset(reset), .dreq(dreq0), .dresp(dresp0),
    .txn_count(txn0), .misalign(mis0));

  dbus_sram_responder #(.MEM_WORDS(MW), .LATENCY(0)) u_lat0 (
    .clk(clk), .reset(reset), .dreq(dreq1), .dresp(dresp1),
    .txn_count(txn1), .misalign(mis1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // reference model: plain word array, counters and sticky flag
  logic [31:0] mem_m [MW];
  int unsigned txn_m = 0;
  bit          mis_m = 0;

  int   last_acc, last_ok;
  logic mis_after_acc;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strb;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;
  vec_t tab [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
  endtask

  task automatic model_apply(input logic [31:0] a, input logic [2:0] s, input logic [3:0] st,
                             input logic [31:0] d, output logic [31:0] exp_rd);
    int i;
    i = int'((a >> 2) % MW);
    exp_rd = mem_m[i];
    for (int b = 0; b < 4; b++)
      if (st[b]) mem_m[i][8*b +: 8] = d[8*b +: 8];
    if ((s == 3'd1 && (a % 2) != 0) || (s == 3'd2 && (a % 4) != 0)) mis_m = 1;
    txn_m++;
  endtask

  // Present a request on the LATENCY=2 instance and follow it to data_ok.
  // Called #1 after a rising edge.
  task automatic run_txn(input logic [31:0] a, input logic [2:0] s, input logic [3:0] st,
                         input logic [31:0] d, output logic [31:0] rd);
    bit done;
    dreq0 = '{valid: 1'b1, addr: a, size: s, strobe: st, data: d};
    last_acc = -1; last_ok = -1; rd = '0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (dresp0.addr_ok) begin last_acc = cyc; done = 1; end
      @(posedge clk); #1;
    end
    dreq0.valid = 1'b0;
    if (!done) begin fail_now("accept"); return; end
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (i == 0) mis_after_acc = mis0;
      if (dresp0.data_ok) begin
        last_ok = cyc; rd = dresp0.data; done = 1;
        chk("addr_ok_in_resp", 32'(dresp0.addr_ok), 32'd0);
      end else begin
        chk("data_zero_wait", dresp0.data, 32'd0);
      end
      @(posedge clk); #1;
    end
    if (!done) fail_now("data_ok");
  endtask

  task automatic do_op(input string nm, input logic [31:0] a, input logic [2:0] s,
                       input logic [3:0] st, input logic [31:0] d,
                       input bit use_tab, input logic [31:0] tab_rd, input logic tab_mis);
    logic [31:0] exp_rd, rd;
    model_apply(a, s, st, d, exp_rd);
    run_txn(a, s, st, d, rd);
    chk({nm, "_data"}, rd, exp_rd);
    if (last_ok >= 0) chk({nm, "_latency"}, 32'(last_ok - last_acc), 32'(LAT + 1));
    chk({nm, "_misalign"}, 32'(mis0), 32'(mis_m));
    chk({nm, "_txn"}, txn0, txn_m);
    if (use_tab) begin
      chk({nm, "_tab_data"}, rd, tab_rd);
      chk({nm, "_mis_early"}, 32'(mis_after_acc), 32'(tab_mis));
    end
  endtask

  initial begin
    logic [31:0] rd, a;
    logic [5:0]  ao, dk;
    int          w_acc, w_ok, overlap;
    bit          seen;

    foreach (mem_m[i]) mem_m[i] = '0;
    dreq0 = '0; dreq1 = '0;
    reset = 1'b1;

    tab[0] = '{32'h20,   3'd2, 4'hF,    32'h1122_3344, 32'h0000_0000, 1'b0};
    tab[1] = '{32'h20,   3'd2, 4'b0101, 32'hAABB_CCDD, 32'h1122_3344, 1'b0};
    tab[2] = '{32'h20,   3'd2, 4'h0,    32'h0,         32'h11BB_33DD, 1'b0};
    tab[3] = '{32'h1004, 3'd2, 4'hF,    32'h5,         32'h0000_0000, 1'b0};
    tab[4] = '{32'h4,    3'd2, 4'h0,    32'h0,         32'h0000_0005, 1'b0};
    tab[5] = '{32'h22,   3'd2, 4'h0,    32'h0,         32'h11BB_33DD, 1'b1};
    tab[6] = '{32'h10,   3'd2, 4'h0,    32'h0,         32'hDEAD_BEEF, 1'b1};
    tab[7] = '{32'h21,   3'd0, 4'h0,    32'h0,         32'h11BB_33DD, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_handshake0", {30'd0, dresp0.addr_ok, dresp0.data_ok}, 32'd0);
    chk("rst_data0", dresp0.data, 32'd0);
    chk("rst_txn0", txn0, 32'd0);
    chk("rst_mis0", 32'(mis0), 32'd0);
    chk("rst_txn1", txn1, 32'd0);
    reset = 1'b0;

    // write then read back with cycle-exact timing
    do_op("wr10", 32'h10, 3'd2, 4'hF, 32'hDEAD_BEEF, 0, 0, 0);
    w_acc = last_acc; w_ok = last_ok;
    do_op("rd10", 32'h10, 3'd2, 4'h0, 32'h0, 1, 32'hDEAD_BEEF, 0);
    chk("wr_dataok_cycle", 32'(w_ok - w_acc), 32'd3);
    chk("rd_accept_cycle", 32'(last_acc - w_acc), 32'd4);
    chk("rd_dataok_cycle", 32'(last_ok - w_acc), 32'd7);
    chk("txn_after_two", txn0, 32'd2);

    for (int i = 0; i < 8; i++)
      do_op($sformatf("tab%0d", i), tab[i].addr, tab[i].size, tab[i].strb, tab[i].data,
            1, tab[i].exp_rd, tab[i].exp_mis);

    // reset during the first WAIT cycle of a write discards it
    dreq0 = '{valid: 1'b1, addr: 32'h30, size: 3'd2, strobe: 4'hF, data: 32'hFFFF_FFFF};
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = dresp0.addr_ok;
      @(posedge clk); #1;
    end
    dreq0.valid = 1'b0;
    if (!seen) fail_now("rst_wr_accept");
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    txn_m = 0; mis_m = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (dresp0.data_ok) seen = 1;
    end
    chk("rst_no_dataok", 32'(seen), 32'd0);
    chk("rst_txn_zero", txn0, 32'd0);
    chk("rst_mis_clear", 32'(mis0), 32'd0);
    @(posedge clk); #1;
    do_op("rd30_after_rst", 32'h30, 3'd2, 4'h0, 32'h0, 1, 32'h0, 0);

    // randomized traffic; small index range so reads hit earlier writes
    for (int n = 0; n < 200; n++) begin
      a = {$urandom_range(0, 32'hFFFFF) & 20'hFFFFF, 5'd0, 5'($urandom_range(0, 31)),
           2'($urandom_range(0, 3))};
      do_op("rnd", a, 3'($urandom_range(0, 2)),
            ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0,
            $urandom, 0, 0, 0);
    end

    // LATENCY=0: valid held for 6 cycles
    dreq1 = '{valid: 1'b1, addr: 32'h10, size: 3'd2, strobe: 4'h0, data: 32'h0};
    ao = '0; dk = '0; overlap = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ao[i] = dresp1.addr_ok;
      dk[i] = dresp1.data_ok;
      if (dresp1.addr_ok && dresp1.data_ok) overlap++;
      @(posedge clk); #1;
    end
    dreq1.valid = 1'b0;
    chk("lat0_addr_ok", 32'(ao), 32'b010101);
    chk("lat0_data_ok", 32'(dk), 32'b101010);
    chk("lat0_overlap", 32'(overlap), 32'd0);
    chk("lat0_txn", txn1, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dbus_sram_responder.md
# dbus_sram_responder

Bus-side responder for the core's data bus: accepts `dbus_req_t` requests from the pipeline's memory stage and answers with `dbus_resp_t` over the addr_ok/data_ok handshake. Backs a word-addressed on-chip SRAM with byte-strobe writes and a programmable response latency. Used as the simulation and FPGA data-memory endpoint and as a latency-injection target for exercising pipeline stall logic.

## Interface
- `MEM_WORDS`, default 1024: SRAM depth in 32-bit words; power of two, 16..65536.
- `LATENCY`, default 2: number of wait cycles between acceptance and response; 0..15.
- `clk`, input, 1: sole clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `dreq`, input, `dbus_req_t`: fields used are `valid`, `addr[31:0]`, `size`, `strobe[3:0]`, `data[31:0]`.
- `dresp`, output, `dbus_resp_t`: fields `addr_ok`, `data_ok`, `data[31:0]`.
- `txn_count`, output, 32: number of completed transactions (data_ok cycles); wraps modulo 2^32.
- `misalign`, output, 1: sticky flag, set when an accepted request is misaligned for its `size`.

## Operation
- FSM with states IDLE, WAIT, RESP.
- IDLE: `dresp.addr_ok = dreq.valid` (combinational). On a cycle with valid=1, the responder latches addr, strobe, data and size, loads the counter with `LATENCY`, and moves to WAIT if `LATENCY > 0`, otherwise to RESP.
- WAIT: addr_ok=0. The counter decrements once per cycle. When the counter reaches 1, the next state is RESP.
- RESP: `data_ok=1` for exactly one cycle, then the FSM returns to IDLE. addr_ok=0 in RESP, so acceptance never overlaps with response.
- Index = latched `addr[log2(MEM_WORDS)+1:2]`. Upper address bits are ignored, so the array aliases modulo MEM_WORDS words. `addr[1:0]` does not affect the index.
- Write: latched strobe != 0. In the RESP cycle edge, byte lane i is written with `data[8i+7:8i]` for each strobe[i]=1. Other lanes are unchanged.
- Read: latched strobe == 0. `dresp.data` = full word at the index during RESP. The core performs byte/half extraction.
- For writes, `dresp.data` in RESP = word value before the write.
- `dresp.data` = 0 whenever data_ok=0.
- Misalign is flagged when `size` is halfword and `addr[0]` != 0, or `size` is word and `addr[1:0]` != 0. The request is still serviced normally. `misalign` stays set until reset.
- `dreq` contents outside IDLE are ignored. The requester holds valid until addr_ok, per the bus protocol.
- SRAM contents are not affected by reset and are zero at time 0.

## Timing
- Reset values: state IDLE, counter 0, `dresp` = all zero, `txn_count` = 0, `misalign` = 0. Reset has priority over every other event.
- Reset asserted in WAIT or RESP: the pending request is discarded. No write occurs, no data_ok is issued, and `txn_count` does not increment.
- Latency: acceptance in cycle T gives data_ok in cycle T+LATENCY+1.
- Throughput: one transaction per LATENCY+2 cycles. With a continuously asserted valid, the next addr_ok is in cycle T+LATENCY+2.
- `txn_count` increments at the edge ending each RESP cycle.
- Read-after-write through separate transactions always returns the written data, because the write commits before IDLE is re-entered.

## Test plan
- LATENCY=2. Write addr 0x0000_0010, strobe 4'hF, data 0xDEAD_BEEF accepted in cycle 0. Then read addr 0x10:
  - write data_ok in cycle 3; read accepted in cycle 4, data_ok in cycle 7 with data 0xDEAD_BEEF; `txn_count` = 2.
- Byte-strobe merge, starting from word 0x1122_3344 at addr 0x20:
  - write strobe 4'b0101, data 0xAABB_CCDD, then read addr 0x20 -> data 0x11BB_33DD.
- Aliasing, MEM_WORDS=1024: write 0x5 to addr 0x0000_1004, read addr 0x0000_0004 -> 0x5.
- Misalign: word read at addr 0x22 -> `misalign` = 1 from the cycle after acceptance, data_ok still occurs, flag persists across the next aligned transaction.
- Reset in first WAIT cycle of a write (strobe 4'hF, data 0xFFFF_FFFF, addr 0x30, previous value 0) -> no data_ok, later read of 0x30 returns 0, `txn_count` = 0.
- LATENCY=0 with valid held high for 6 cycles -> addr_ok in cycles 0, 2, 4 and data_ok in cycles 1, 3, 5; never both in the same cycle.
